// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start/busy/done handshake plus data.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice with a registered carry, one bit per clock.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_sum;
  logic               fa_carry;

  // Single full-adder slice on the LSBs of the operand shift registers
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_sum, s_q[WIDTH-1:1]};
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry entering the MSB slice
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: timestamp-based reference model, directed
// cases with literal results, and randomized traffic including mid-operation resets.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c);
    longint sx, sy, r;
    sx = longint'(x);
    sy = longint'(y);
    if (x[W-1]) sx = sx - (longint'(1) << W);
    if (y[W-1]) sy = sy - (longint'(1) << W);
    r = sx + sy + longint'(c);
    return (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
  endfunction

  // Reference model: an op accepted at edge s shows busy after edges s..s+W-1,
  // done and the new result after edge s+W, and can be followed from edge s+W+2.
  int           k = 0;
  int           m_s = 0;
  logic         m_valid = 1'b0;
  logic [W:0]   m_res = '0;
  logic         m_ov = 1'b0;
  logic         e_busy = 1'b0;
  logic         e_done = 1'b0;
  logic [W-1:0] e_sum = '0;
  logic         e_cout = 1'b0;
  logic         e_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      e_busy  <= 1'b0;
      e_done  <= 1'b0;
      e_sum   <= '0;
      e_cout  <= 1'b0;
      e_ovf   <= 1'b0;
    end else if (bus.start && (!m_valid || k >= m_s + W + 2)) begin
      m_valid <= 1'b1;
      m_s     <= k;
      m_res   <= {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
      m_ov    <= signed_ovf(bus.a, bus.b, bus.cin);
      e_busy  <= 1'b1;
      e_done  <= 1'b0;
    end else begin
      e_busy <= m_valid && (k < m_s + W);
      e_done <= m_valid && (k == m_s + W);
      if (m_valid && (k == m_s + W)) begin
        {e_cout, e_sum} <= m_res;
        e_ovf           <= m_ov;
      end
    end
    k <= k + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 64'(bus.busy), 64'(e_busy));
      cmp("done", 64'(bus.done), 64'(e_done));
      cmp("sum",  64'(bus.sum),  64'(e_sum));
      cmp("cout", 64'(bus.cout), 64'(e_cout));
`ifdef SERIAL_ADDER_OVF_EN
      cmp("ovf",  64'(bus.ovf),  64'(e_ovf));
`endif
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) cmp("idle_timeout", 64'(n), 64'(0));
  endtask

  // Single start pulse; returns result at the done cycle, latency in cycles and busy count.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       output logic [W-1:0] rs, output logic rc, output int lat,
                       output int nbusy);
    wait_idle();
    bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = 1;
    nbusy = 0;
    while (bus.done !== 1'b1 && lat < 64) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) cmp("done_timeout", 64'(lat), 64'(W + 1));
    rs = bus.sum;
    rc = bus.cout;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat, nb, nd;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat, nb, nd;

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      cmp("rst_busy", 64'(bus.busy), 64'(0));
      cmp("rst_done", 64'(bus.done), 64'(0));
      cmp("rst_sum",  64'(bus.sum),  64'h00);
      cmp("rst_cout", 64'(bus.cout), 64'(0));
    end

    do_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, nb);
    cmp("ff01_sum",  64'(rs),  64'h00);
    cmp("ff01_cout", 64'(rc),  64'(1));
    cmp("ff01_lat",  64'(lat), 64'(W + 1));
    cmp("ff01_busy_cycles", 64'(nb), 64'(W));

    do_op(8'h5A, 8'hA5, 1'b1, rs, rc, lat, nb);
    cmp("5aa5_sum",  64'(rs), 64'h00);
    cmp("5aa5_cout", 64'(rc), 64'(1));
    do_op(8'h12, 8'h34, 1'b0, rs, rc, lat, nb);
    cmp("1234_sum",  64'(rs), 64'h46);
    cmp("1234_cout", 64'(rc), 64'(0));

    // start and operand changes during SHIFT must be ignored
    wait_idle();
    bus.a = 8'h03; bus.b = 8'h04; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.a = 8'hFF; bus.b = W'($urandom); bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom);
    nd = 0; rs = '0; rc = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin nd++; rs = bus.sum; rc = bus.cout; end
    end
    cmp("ign_dones", 64'(nd), 64'(1));
    cmp("ign_sum",   64'(rs), 64'h07);
    cmp("ign_cout",  64'(rc), 64'(0));

    // reset in the middle of an operation
    wait_idle();
    bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", 64'(bus.busy), 64'(0));
    cmp("abort_done", 64'(bus.done), 64'(0));
    cmp("abort_sum",  64'(bus.sum),  64'h00);
    cmp("abort_cout", 64'(bus.cout), 64'(0));
    nd = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    cmp("abort_no_done", 64'(nd), 64'(0));
    do_op(8'h80, 8'h80, 1'b0, rs, rc, lat, nb);
    cmp("8080_sum",  64'(rs), 64'h00);
    cmp("8080_cout", 64'(rc), 64'(1));

`ifdef SERIAL_ADDER_OVF_EN
    do_op(8'h7F, 8'h01, 1'b0, rs, rc, lat, nb);
    cmp("7f01_sum",  64'(rs), 64'h80);
    cmp("7f01_cout", 64'(rc), 64'(0));
    cmp("7f01_ovf",  64'(bus.ovf), 64'(1));
    do_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, nb);
    cmp("ff01_ovf",  64'(bus.ovf), 64'(0));
`endif

    // start held high: back-to-back operations every W+2 cycles
    wait_idle();
    bus.start = 1'b1;
    nd = 0;
    repeat (5 * (W + 2)) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    bus.start = 1'b0;
    cmp("b2b_dones", 64'(nd), 64'(5));

    // random traffic with occasional resets
    repeat (600) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
